// File: rtl/usb_rx_word_packer.sv
// Packs received USB bytes big-endian into 32-bit words, with inter-byte timeout and error discard.
// Optional checksum byte (fifth byte = XOR of the four data bytes) enabled by USB_RX_CHECKSUM_EN.
module usb_rx_word_packer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        new_byte,
    input  logic [7:0]  data_in,
    input  logic        byte_error,
    input  logic        data_ack,
    output logic [31:0] stock_data,
    output logic        data_ready,
    output logic        overrun,
    output logic        frame_error,
    output logic        checksum_error
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef USB_RX_CHECKSUM_EN
    localparam int unsigned N = 5;
`else
    localparam int unsigned N = 4;
`endif
    // Shift register only holds the bytes that precede the final one.
    localparam int unsigned SHW = (N - 1) * 8;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          state, state_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic [SHW-1:0]  shreg, shreg_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [31:0]     word, stock_nxt;
    logic            complete;
    logic            ready_nxt, overrun_nxt, ferr_nxt;
`ifdef USB_RX_CHECKSUM_EN
    logic            cerr_nxt;
    logic [7:0]      xsum;

    assign xsum = shreg[31:24] ^ shreg[23:16] ^ shreg[15:8] ^ shreg[7:0];
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            timer       <= '0;
            stock_data  <= '0;
            data_ready  <= 1'b0;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            shreg       <= shreg_nxt;
            timer       <= timer_nxt;
            stock_data  <= stock_nxt;
            data_ready  <= ready_nxt;
            overrun     <= overrun_nxt;
            frame_error <= ferr_nxt;
        end
    end

`ifdef USB_RX_CHECKSUM_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) checksum_error <= 1'b0;
        else        checksum_error <= cerr_nxt;
    end
`else
    assign checksum_error = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        timer_nxt   = timer;
        word        = '0;
        complete    = 1'b0;
        ferr_nxt    = 1'b0;
`ifdef USB_RX_CHECKSUM_EN
        cerr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                timer_nxt = '0;
                // A byte flagged corrupt in the same cycle never starts a word.
                if (new_byte && !byte_error) begin
                    state_nxt = COLLECT;
                    cnt_nxt   = 3'd1;
                    shreg_nxt = SHW'(data_in);
                end
            end
            COLLECT: begin
                if (byte_error) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                    timer_nxt = '0;
                    ferr_nxt  = 1'b1;
                end else if (new_byte) begin
                    timer_nxt = '0;
                    if (cnt == 3'(N - 1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        shreg_nxt = '0;
`ifdef USB_RX_CHECKSUM_EN
                        word = shreg;
                        if (data_in == xsum) complete = 1'b1;
                        else                 cerr_nxt = 1'b1;
`else
                        word     = {shreg, data_in};
                        complete = 1'b1;
`endif
                    end else begin
                        cnt_nxt   = cnt + 3'd1;
                        shreg_nxt = {shreg[SHW-9:0], data_in};
                    end
                end else if (timer >= T_LAST) begin
                    // Last of TIMEOUT_CYCLES idle cycles since the previous byte.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                    timer_nxt = '0;
                    ferr_nxt  = 1'b1;
                end else if (timer != T_MAX) begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                shreg_nxt = '0;
                timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        stock_nxt   = stock_data;
        ready_nxt   = data_ready & ~data_ack;
        overrun_nxt = 1'b0;
        if (complete) begin
            stock_nxt   = word;
            ready_nxt   = 1'b1;
            overrun_nxt = data_ready & ~data_ack;
        end
    end

endmodule
